// File: rtl/fracnet_t_acc_requant_pkg.sv
// Shared types and default widths for the 3x3 accumulate/requantize stage.
// Modules override these through parameters; these are the reference build values.
package fracnet_t_acc_requant_pkg;

  localparam int PROD_W    = 27;
  localparam int NUM_TERMS = 9;
  localparam int ACC_W     = 32;
  localparam int SHIFT     = 6;
  localparam int OUT_W     = 16;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

endpackage

// File: rtl/fracnet_t_acc_requant_if.sv
// Product-in / result-out handshake bundle for the accumulate/requantize stage.
// slave is the accumulator side, master is the producer/consumer side.
interface fracnet_t_acc_requant_if #(
  parameter int PROD_W = 27,
  parameter int OUT_W  = 16
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_prod;
  logic signed [OUT_W-1:0]  in_bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_ovf;

  modport slave (
    input  in_valid, in_prod, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_prod, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/fracnet_t_round_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, then clamp to OUT_W signed.
// One extra bit of headroom keeps the rounding add from wrapping at the positive accumulator limit.
module fracnet_t_round_sat #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    ovf_o
);

  localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  always_comb begin
    sum    = {acc_i[ACC_W-1], acc_i} + $signed(HALF);
    r      = sum >>> SHIFT;
    data_o = r[OUT_W-1:0];
    ovf_o  = 1'b0;
    if (r > MAX_V) begin
      data_o = MAX_V[OUT_W-1:0];
      ovf_o  = 1'b1;
    end else if (r < MIN_V) begin
      data_o = MIN_V[OUT_W-1:0];
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fracnet_t_acc_requant.sv
// Sums NUM_TERMS signed products plus a pre-scaled bias, then requantizes to OUT_W with saturation.
// Result is registered one cycle after the last term; in_ready/out_valid come straight from state.
module fracnet_t_acc_requant #(
  parameter int PROD_W    = fracnet_t_acc_requant_pkg::PROD_W,
  parameter int NUM_TERMS = fracnet_t_acc_requant_pkg::NUM_TERMS,
  parameter int ACC_W     = fracnet_t_acc_requant_pkg::ACC_W,
  parameter int SHIFT     = fracnet_t_acc_requant_pkg::SHIFT,
  parameter int OUT_W     = fracnet_t_acc_requant_pkg::OUT_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  fracnet_t_acc_requant_if.slave   bus
);

  import fracnet_t_acc_requant_pkg::*;

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  if (ACC_W < PROD_W + $clog2(NUM_TERMS) + 1) begin : g_acc_w_chk
    $error("ACC_W too narrow for PROD_W and NUM_TERMS");
  end
  if (SHIFT < 1 || SHIFT > ACC_W - OUT_W) begin : g_shift_chk
    $error("SHIFT out of range 1..ACC_W-OUT_W");
  end

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  data_q, data_d;
  logic                     ovf_q, ovf_d;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_sh;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [OUT_W-1:0]  rs_data;
  logic                     rs_ovf;

  // Bias is in output units, so it is pre-scaled into accumulator units before the first term.
  assign prod_ext = {{(ACC_W - PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
  assign bias_sh  = {{(ACC_W - OUT_W){bus.in_bias[OUT_W-1]}}, bus.in_bias} <<< SHIFT;
  assign acc_sum  = ((cnt_q == '0) ? bias_sh : acc_q) + prod_ext;

  fracnet_t_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc_i  (acc_sum),
    .data_o (rs_data),
    .ovf_o  (rs_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACC: begin
        if (bus.in_valid) begin
          acc_d = acc_sum;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            data_d  = rs_data;
            ovf_d   = rs_ovf;
            state_d = ST_OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = data_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_fracnet_t_acc_requant.sv
// Directed vectors for the accumulate/requantize stage at default parameters.
// Table of full-group vectors plus hand sequences for backpressure, gapped input and mid-group reset.
module tb_fracnet_t_acc_requant;

  localparam int PROD_W = 27;
  localparam int OUT_W  = 16;

  typedef struct {
    string                    name;
    logic signed [PROD_W-1:0] prod;
    logic                     first_only;
    logic signed [OUT_W-1:0]  bias;
    logic signed [OUT_W-1:0]  exp_data;
    logic                     exp_ovf;
  } vec_t;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  vec_t vecs[7];

  always #5 ap_clk = ~ap_clk;

  fracnet_t_acc_requant_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

  fracnet_t_acc_requant dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  always @(negedge ap_clk) begin
    if (ap_rst_n && bus.out_valid && bus.out_ready) n_out <= n_out + 1;
  end

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Presents NUM_TERMS terms; returns 1 cycle after the last accepted term.
  task automatic send_group(input logic signed [PROD_W-1:0] prod, input logic first_only,
                            input logic signed [OUT_W-1:0] bias, input logic gap);
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = (first_only && i != 0) ? '0 : prod;
      bus.in_bias  = bias;
      tick();
      bus.in_valid = 1'b0;
      if (gap && i < 8) tick();
    end
  endtask

  initial begin
    int out_before;

    vecs[0] = '{"ones100",  27'sd100,       1'b0, 16'sd0,  16'sd14,     1'b0};
    vecs[1] = '{"sat_pos",  27'sd16777216,  1'b0, 16'sd0,  16'sd32767,  1'b1};
    vecs[2] = '{"sat_neg", -27'sd16777216,  1'b0, 16'sd0, -16'sd32768,  1'b1};
    vecs[3] = '{"round_up", 27'sd32,        1'b1, 16'sd0,  16'sd1,      1'b0};
    vecs[4] = '{"bias5",    27'sd0,         1'b0, 16'sd5,  16'sd5,      1'b0};
    vecs[5] = '{"neg64",   -27'sd64,        1'b0, 16'sd0, -16'sd9,      1'b0};
    vecs[6] = '{"bias_neg", 27'sd0,         1'b0, -16'sd3, -16'sd3,     1'b0};

    ap_rst_n      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_bias   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_ovf",   bus.out_ovf,   0);

    foreach (vecs[k]) begin
      send_group(vecs[k].prod, vecs[k].first_only, vecs[k].bias, 1'b0);
      check({vecs[k].name, "_valid"}, bus.out_valid, 1);
      check({vecs[k].name, "_data"},  bus.out_data,  vecs[k].exp_data);
      check({vecs[k].name, "_ovf"},   bus.out_ovf,   vecs[k].exp_ovf);
      check({vecs[k].name, "_rdy_lo"}, bus.in_ready, 0);
      tick();
      check({vecs[k].name, "_valid_1cyc"}, bus.out_valid, 0);
      check({vecs[k].name, "_rdy_back"},   bus.in_ready,  1);
    end

    // Backpressure: result must hold and stray input pulses must not be absorbed.
    bus.out_ready = 1'b0;
    send_group(27'sd100, 1'b0, 16'sd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = 27'sd5000;
      check("bp_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_data", bus.out_data, 14);
      tick();
    end
    bus.in_valid  = 1'b0;
    check("bp_data_held", bus.out_data, 14);
    bus.out_ready = 1'b1;
    tick();
    check("bp_released", bus.out_valid, 0);
    check("bp_in_ready_back", bus.in_ready, 1);
    send_group(27'sd100, 1'b0, 16'sd0, 1'b0);
    check("bp_next_group_valid", bus.out_valid, 1);
    check("bp_next_group_data", bus.out_data, 14);
    tick();

    // Gapped input gives the same result as back-to-back.
    send_group(27'sd100, 1'b0, 16'sd0, 1'b1);
    check("gap_valid", bus.out_valid, 1);
    check("gap_data",  bus.out_data,  14);
    check("gap_ovf",   bus.out_ovf,   0);
    tick();

    // Reset mid-group discards the partial sum.
    out_before = n_out;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = 27'sd1000;
      bus.in_bias  = '0;
      tick();
    end
    bus.in_valid = 1'b0;
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    send_group(27'sd100, 1'b0, 16'sd0, 1'b0);
    check("mid_rst_out_valid", bus.out_valid, 1);
    check("mid_rst_data", bus.out_data, 14);
    tick();
    tick();
    check("mid_rst_out_count", n_out - out_before, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no summary, expected finish");
    $fatal(1);
  end

endmodule
